mc_controller: RTL and testbench
================================

# mc_controller

Multi-cycle main controller for the MIPS core: a state machine that sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state write enables and datapath selects. It extends the single-cycle decoder with four instructions: mult, div, mfhi and mflo. mult and div use a parametrised-latency MDU wait state with a busy indication. It sits between the IR/zero flag and the multi-cycle datapath (PC, IR, GRF, ALU, DM, HI/LO).

## Interface
- MULT_CYCLES, 5: cycles spent in MDWAIT for mult; legal range ≥1.
- DIV_CYCLES, 10: cycles spent in MDWAIT for div; legal range ≥1.
- CNT_W, $clog2(max(MULT_CYCLES,DIV_CYCLES)+1): MDU counter width (derived).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  IR contents. Valid from DECODE onward.
- zero  in  1  ALU equality flag. Sampled in EXEC for beq.
- irWrite, pcWrite, regWrite, memWrite  out  1 each  write enables.
- hiloWrite  out  1  commits the MDU result to HI/LO.
- mdStart  out  1  one-cycle MDU launch pulse.
- mdOp  out  1  MDU operation: 0 = mult, 1 = div.
- mdBusy  out  1  high throughout MDWAIT.
- RegDst  out  2  GRF write-address select. Uses the grfWR_* codes from macros.v.
- ALUSrc  out  2  ALU B select. Uses the aluB_* codes.
- WBreg  out  2  GRF write-data select. Uses grfWD_ALUOut, grfWD_DMout and grfWD_pc8, plus the new grfWD_HiLo = 2'b11.
- hiloSel  out  1  HI/LO read select: 0 = LO, 1 = HI.
- PCSrc  out  3  Uses pc_4, b_type, j_jump and j_reg.
- EXTOp  out  2  Uses extZero, extSign and extLui.
- ALUOp  out  3  Uses aluAdd, aluSub, aluOr, aluLui_save and aluAnd.
- state  out  3  current state, for debug and the testbench.

## Operation
- Decode (opcode/funct, standard MIPS)
  - R-type funct values: add 100000, sub 100010, jr 001000, mult 011000, div 011010, mfhi 010000, mflo 010010.
  - Opcodes: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111, jal 000011.
  - Any other encoding is undefined.
- Encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MDWAIT=5. Codes 6 and 7 go to FETCH on the next edge with all enables low.
- FETCH: irWrite=1, pcWrite=1, PCSrc=pc_4. Next state DECODE.
- DECODE: no enables. Undefined instructions go to FETCH (NOP); everything else goes to EXEC.
- EXEC: ALUOp, ALUSrc and EXTOp as for the single-cycle decode. Per instruction:
  - beq: pcWrite=zero, PCSrc=b_type; next FETCH.
  - jr: pcWrite=1, PCSrc=j_reg; next FETCH.
  - jal: pcWrite=1, PCSrc=j_jump, regWrite=1, RegDst=grfWR_ra, WBreg=grfWD_pc8; next FETCH. pc8 is computed from the PC sampled before this edge.
  - mult/div: mdStart=1, mdOp set, counter loaded with MULT_CYCLES or DIV_CYCLES; next MDWAIT.
  - lw/sw: next MEM.
  - add/sub/ori/lui/mfhi/mflo: next WB.
- MEM: sw drives memWrite=1 and goes to FETCH; lw goes to WB.
- WB: regWrite=1. Selects per instruction:
  - RegDst: rd for add/sub/mfhi/mflo; rt for ori/lui/lw.
  - WBreg: DMout for lw; HiLo for mfhi/mflo; ALUOut otherwise.
  - hiloSel: 1 for mfhi.
  - Next FETCH.
- MDWAIT: mdBusy=1 and the counter decrements each cycle. In the cycle where counter==1: hiloWrite=1, next FETCH.
- Outside MDWAIT, mdBusy=0 and the counter holds. Outside their listed states, all enables are 0.
- Select outputs are purely combinational from state and instr. In states where a select is unused, it drives the default code (first listed).

## Timing
- State and counter registers update on the rising edge of clk. Reset forces them immediately (asynchronous): state=FETCH, counter=0.
- While reset is low, every enable output (irWrite, pcWrite, regWrite, memWrite, hiloWrite, mdStart), mdBusy, and the select outputs are forced to 0. Release takes effect at the first rising edge after reset goes high; that edge performs the FETCH.
- Cycles per instruction, FETCH included:
  - beq, jr, jal: 3
  - add, sub, ori, lui, sw, mfhi, mflo: 4
  - lw: 5
  - mult: 3+MULT_CYCLES
  - div: 3+DIV_CYCLES
  - undefined: 2
- mdStart is high for exactly one cycle, in EXEC. hiloWrite is high for exactly one cycle, the last MDWAIT cycle.
- Reset asserted during MDWAIT:
  - Abort immediately: mdBusy drops and hiloWrite is never issued.
  - The counter is cleared, so a later mult/div reloads the full latency.
- An mfhi/mflo following mult/div needs no interlock: HI/LO is already committed when FETCH resumes.

## Test plan
- Reset: hold reset low 3 cycles, then release → state=FETCH and all enables 0 during reset; irWrite=pcWrite=1 in the first cycle after release.
- add $3,$1,$2 (0x00221820) → states 0,1,2,4,0. regWrite=1 only in WB, with RegDst=rd and WBreg=ALUOut.
- lw then sw:
  - lw (0x8C220004) → 5 cycles, memWrite never set.
  - sw (0xAC220004) → 4 cycles, memWrite=1 only in MEM.
- beq (0x10220003):
  - zero=1 → pcWrite=1 in EXEC with PCSrc=b_type.
  - zero=0 → pcWrite=0 in EXEC.
  - Both cases take 3 cycles.
- mult (0x00220018), default parameters:
  - mdStart pulses once; mdBusy is high for 5 cycles; hiloWrite on the 5th cycle; 8 cycles total.
  - Rerun with DIV_CYCLES=1 on div: mdBusy is high for exactly 1 cycle.
- Abort and undefined:
  - Assert reset in the 3rd MDWAIT cycle of div → mdBusy=0 immediately and no hiloWrite.
  - Undefined opcode 0xFC000000 → 2 cycles with no enables after FETCH.

Source files
------------

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS main controller with mult/div wait state
module mc_controller #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = $clog2(((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        zero,
   output logic        irWrite,
   output logic        pcWrite,
   output logic        regWrite,
   output logic        memWrite,
   output logic        hiloWrite,
   output logic        mdStart,
   output logic        mdOp,
   output logic        mdBusy,
   output logic [1:0]  RegDst,
   output logic [1:0]  ALUSrc,
   output logic [1:0]  WBreg,
   output logic        hiloSel,
   output logic [2:0]  PCSrc,
   output logic [1:0]  EXTOp,
   output logic [2:0]  ALUOp,
   output logic [2:0]  state
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_MDWAIT = 3'd5;

   localparam logic [1:0] GRFWR_RT = 2'd0, GRFWR_RD = 2'd1, GRFWR_RA = 2'd2;
   localparam logic [1:0] ALUB_RT = 2'd0, ALUB_EXT = 2'd1;
   localparam logic [1:0] GRFWD_ALUOUT = 2'd0, GRFWD_DMOUT = 2'd1, GRFWD_PC8 = 2'd2, GRFWD_HILO = 2'd3;
   localparam logic [2:0] PC_4 = 3'd0, B_TYPE = 3'd1, J_JUMP = 3'd2, J_REG = 3'd3;
   localparam logic [1:0] EXT_ZERO = 2'd0, EXT_SIGN = 2'd1, EXT_LUI = 2'd2;
   localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_OR = 3'd2, ALU_LUI_SAVE = 3'd3;

   logic [2:0]       cur, nxt;
   logic [CNT_W-1:0] cnt;

   wire [5:0] op    = instr[31:26];
   wire [5:0] funct = instr[5:0];
   wire       rtype = (op == 6'h00);

   wire is_add  = rtype && funct == 6'h20;
   wire is_sub  = rtype && funct == 6'h22;
   wire is_jr   = rtype && funct == 6'h08;
   wire is_mult = rtype && funct == 6'h18;
   wire is_div  = rtype && funct == 6'h1a;
   wire is_mfhi = rtype && funct == 6'h10;
   wire is_mflo = rtype && funct == 6'h12;
   wire is_ori  = (op == 6'h0d);
   wire is_lw   = (op == 6'h23);
   wire is_sw   = (op == 6'h2b);
   wire is_beq  = (op == 6'h04);
   wire is_lui  = (op == 6'h0f);
   wire is_jal  = (op == 6'h03);

   wire is_md   = is_mult || is_div;
   wire to_wb   = is_add || is_sub || is_ori || is_lui || is_mfhi || is_mflo;
   wire defined = to_wb || is_md || is_lw || is_sw || is_beq || is_jr || is_jal;
   wire md_last = (cnt <= CNT_W'(1));

   logic unused_bits;
   assign unused_bits = ^instr[25:6];

   assign state = cur;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur <= S_FETCH;
         cnt <= '0;
      end else begin
         cur <= nxt;
         if (cur == S_EXEC && is_md)
            cnt <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
         else if (cur == S_MDWAIT)
            cnt <= cnt - CNT_W'(1);
      end
   end

   always_comb begin
      nxt       = S_FETCH;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      regWrite  = 1'b0;
      memWrite  = 1'b0;
      hiloWrite = 1'b0;
      mdStart   = 1'b0;
      mdOp      = 1'b0;
      mdBusy    = 1'b0;
      RegDst    = GRFWR_RT;
      ALUSrc    = ALUB_RT;
      WBreg     = GRFWD_ALUOUT;
      hiloSel   = 1'b0;
      PCSrc     = PC_4;
      EXTOp     = EXT_ZERO;
      ALUOp     = ALU_ADD;
      case (cur)
         S_FETCH: begin
            irWrite = 1'b1;
            pcWrite = 1'b1;
            nxt     = S_DECODE;
         end
         S_DECODE: nxt = defined ? S_EXEC : S_FETCH;
         S_EXEC: begin
            // ALU controls mirror the single-cycle decoder
            if (is_sub || is_beq) ALUOp = ALU_SUB;
            if (is_ori)           ALUOp = ALU_OR;
            if (is_lui)           ALUOp = ALU_LUI_SAVE;
            if (is_ori || is_lui || is_lw || is_sw) ALUSrc = ALUB_EXT;
            if (is_lw || is_sw)   EXTOp = EXT_SIGN;
            if (is_lui)           EXTOp = EXT_LUI;
            if (is_beq) begin
               pcWrite = zero;
               PCSrc   = B_TYPE;
            end else if (is_jr) begin
               pcWrite = 1'b1;
               PCSrc   = J_REG;
            end else if (is_jal) begin
               pcWrite  = 1'b1;
               PCSrc    = J_JUMP;
               regWrite = 1'b1;
               RegDst   = GRFWR_RA;
               WBreg    = GRFWD_PC8;
            end else if (is_md) begin
               mdStart = 1'b1;
               mdOp    = is_div;
               nxt     = S_MDWAIT;
            end else if (is_lw || is_sw) begin
               nxt = S_MEM;
            end else if (to_wb) begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            memWrite = is_sw;
            if (is_lw) nxt = S_WB;
         end
         S_WB: begin
            regWrite = 1'b1;
            if (is_add || is_sub || is_mfhi || is_mflo) RegDst = GRFWR_RD;
            if (is_lw)              WBreg = GRFWD_DMOUT;
            if (is_mfhi || is_mflo) WBreg = GRFWD_HILO;
            hiloSel = is_mfhi;
         end
         S_MDWAIT: begin
            mdBusy    = 1'b1;
            mdOp      = is_div;
            hiloWrite = md_last;
            nxt       = md_last ? S_FETCH : S_MDWAIT;
         end
         default: nxt = S_FETCH;
      endcase
      // reset gates the decoded outputs so FETCH does not fire while held
      if (!reset) begin
         irWrite   = 1'b0;
         pcWrite   = 1'b0;
         regWrite  = 1'b0;
         memWrite  = 1'b0;
         hiloWrite = 1'b0;
         mdStart   = 1'b0;
         mdOp      = 1'b0;
         mdBusy    = 1'b0;
         RegDst    = 2'd0;
         ALUSrc    = 2'd0;
         WBreg     = 2'd0;
         hiloSel   = 1'b0;
         PCSrc     = 3'd0;
         EXTOp     = 2'd0;
         ALUOp     = 3'd0;
      end
   end

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - randomized bench for mc_controller against a per-cycle model
module tb_mc_controller;

   typedef struct packed {
      logic [2:0] st;
      logic       ir, pc, rw, mw, hw, ms, mo, mb;
      logic [1:0] rd, as, wb;
      logic       hs;
      logic [2:0] ps;
      logic [1:0] eo;
      logic [2:0] ao;
   } outs_t;

   localparam int C_ADD = 0, C_SUB = 1, C_ORI = 2, C_LW = 3, C_SW = 4, C_BEQ = 5, C_LUI = 6;
   localparam int C_JAL = 7, C_JR = 8, C_MULT = 9, C_DIV = 10, C_MFHI = 11, C_MFLO = 12, C_UND = 13;

   logic        clk;
   logic        reset_a, reset_b;
   logic [31:0] instr;
   logic        zero;
   int          vectors;
   int          miscompares;

   logic        irWrite_a, pcWrite_a, regWrite_a, memWrite_a, hiloWrite_a, mdStart_a, mdOp_a, mdBusy_a, hiloSel_a;
   logic [1:0]  RegDst_a, ALUSrc_a, WBreg_a, EXTOp_a;
   logic [2:0]  PCSrc_a, ALUOp_a, state_a;
   logic        irWrite_b, pcWrite_b, regWrite_b, memWrite_b, hiloWrite_b, mdStart_b, mdOp_b, mdBusy_b, hiloSel_b;
   logic [1:0]  RegDst_b, ALUSrc_b, WBreg_b, EXTOp_b;
   logic [2:0]  PCSrc_b, ALUOp_b, state_b;
   outs_t       obs_a, obs_b;

   mc_controller dut_a (
      .clk(clk), .reset(reset_a), .instr(instr), .zero(zero),
      .irWrite(irWrite_a), .pcWrite(pcWrite_a), .regWrite(regWrite_a), .memWrite(memWrite_a),
      .hiloWrite(hiloWrite_a), .mdStart(mdStart_a), .mdOp(mdOp_a), .mdBusy(mdBusy_a),
      .RegDst(RegDst_a), .ALUSrc(ALUSrc_a), .WBreg(WBreg_a), .hiloSel(hiloSel_a),
      .PCSrc(PCSrc_a), .EXTOp(EXTOp_a), .ALUOp(ALUOp_a), .state(state_a)
   );

   mc_controller #(.DIV_CYCLES(1)) dut_b (
      .clk(clk), .reset(reset_b), .instr(instr), .zero(zero),
      .irWrite(irWrite_b), .pcWrite(pcWrite_b), .regWrite(regWrite_b), .memWrite(memWrite_b),
      .hiloWrite(hiloWrite_b), .mdStart(mdStart_b), .mdOp(mdOp_b), .mdBusy(mdBusy_b),
      .RegDst(RegDst_b), .ALUSrc(ALUSrc_b), .WBreg(WBreg_b), .hiloSel(hiloSel_b),
      .PCSrc(PCSrc_b), .EXTOp(EXTOp_b), .ALUOp(ALUOp_b), .state(state_b)
   );

   assign obs_a = {state_a, irWrite_a, pcWrite_a, regWrite_a, memWrite_a, hiloWrite_a, mdStart_a,
                   mdOp_a, mdBusy_a, RegDst_a, ALUSrc_a, WBreg_a, hiloSel_a, PCSrc_a, EXTOp_a, ALUOp_a};
   assign obs_b = {state_b, irWrite_b, pcWrite_b, regWrite_b, memWrite_b, hiloWrite_b, mdStart_b,
                   mdOp_b, mdBusy_b, RegDst_b, ALUSrc_b, WBreg_b, hiloSel_b, PCSrc_b, EXTOp_b, ALUOp_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int instr_len(input int cls, input int lat);
      case (cls)
         C_BEQ, C_JR, C_JAL: return 3;
         C_LW:               return 5;
         C_MULT, C_DIV:      return 3 + lat;
         C_UND:              return 2;
         default:            return 4;
      endcase
   endfunction

   // Expected outputs for cycle k (0 = FETCH) of one instruction of class cls.
   function automatic outs_t model(input int cls, input int k, input logic z, input int lat);
      outs_t o;
      int    wb_k;
      o    = '0;
      wb_k = (cls == C_LW) ? 4 : 3;
      if (k == 0) begin
         o.ir = 1'b1;
         o.pc = 1'b1;
      end else if (k == 1) begin
         o.st = 3'd1;
      end else if (k == 2) begin
         o.st = 3'd2;
         case (cls)
            C_SUB:       o.ao = 3'd1;
            C_ORI:       begin o.ao = 3'd2; o.as = 2'd1; end
            C_LW, C_SW:  begin o.as = 2'd1; o.eo = 2'd1; end
            C_BEQ:       begin o.ao = 3'd1; o.pc = z; o.ps = 3'd1; end
            C_LUI:       begin o.ao = 3'd3; o.as = 2'd1; o.eo = 2'd2; end
            C_JR:        begin o.pc = 1'b1; o.ps = 3'd3; end
            C_JAL:       begin o.pc = 1'b1; o.ps = 3'd2; o.rw = 1'b1; o.rd = 2'd2; o.wb = 2'd2; end
            C_MULT:      o.ms = 1'b1;
            C_DIV:       begin o.ms = 1'b1; o.mo = 1'b1; end
            default:     ;
         endcase
      end else if (cls == C_MULT || cls == C_DIV) begin
         o.st = 3'd5;
         o.mb = 1'b1;
         o.mo = (cls == C_DIV);
         o.hw = (k == lat + 2);
      end else if (k == 3 && (cls == C_LW || cls == C_SW)) begin
         o.st = 3'd3;
         o.mw = (cls == C_SW);
      end else if (k == wb_k) begin
         o.st = 3'd4;
         o.rw = 1'b1;
         o.rd = (cls == C_ADD || cls == C_SUB || cls == C_MFHI || cls == C_MFLO) ? 2'd1 : 2'd0;
         o.wb = (cls == C_LW) ? 2'd1 : ((cls == C_MFHI || cls == C_MFLO) ? 2'd3 : 2'd0);
         o.hs = (cls == C_MFHI);
      end
      return o;
   endfunction

   function automatic logic [31:0] enc(input int cls);
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  op, f;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      case (cls)
         C_ADD:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
         C_SUB:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
         C_JR:   return {6'h00, rs, rt, rd, 5'd0, 6'h08};
         C_MULT: return {6'h00, rs, rt, rd, 5'd0, 6'h18};
         C_DIV:  return {6'h00, rs, rt, rd, 5'd0, 6'h1a};
         C_MFHI: return {6'h00, rs, rt, rd, 5'd0, 6'h10};
         C_MFLO: return {6'h00, rs, rt, rd, 5'd0, 6'h12};
         C_ORI:  return {6'h0d, rs, rt, imm};
         C_LW:   return {6'h23, rs, rt, imm};
         C_SW:   return {6'h2b, rs, rt, imm};
         C_BEQ:  return {6'h04, rs, rt, imm};
         C_LUI:  return {6'h0f, rs, rt, imm};
         C_JAL:  return {6'h03, rs, rt, imm};
         default: begin
            if ($urandom_range(0, 1) == 0) begin
               do op = 6'($urandom_range(1, 63));
               while (op inside {6'h0d, 6'h23, 6'h2b, 6'h04, 6'h0f, 6'h03});
               return {op, rs, rt, imm};
            end
            case ($urandom_range(0, 3))
               0:       f = 6'h01;
               1:       f = 6'h21;
               2:       f = 6'h2a;
               default: f = 6'h3f;
            endcase
            return {6'h00, rs, rt, rd, 5'd0, f};
         end
      endcase
   endfunction

   task automatic check(input outs_t exp, input int which, input string tag, input int k);
      outs_t obs;
      obs = (which != 0) ? obs_b : obs_a;
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s cyc%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // Instr/zero change at the FETCH sample point, where no decision depends on them.
   task automatic run(input logic [31:0] i, input int cls, input logic z, input int which, input string tag);
      int lat, n;
      lat = (cls == C_MULT) ? 5 : ((which != 0) ? 1 : 10);
      n   = instr_len(cls, lat);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (k == 0) begin
            instr = i;
            zero  = z;
         end
         check(model(cls, k, z, lat), which, tag, k);
      end
   endtask

   initial begin
      int cls;
      vectors     = 0;
      miscompares = 0;
      reset_a     = 1'b0;
      reset_b     = 1'b0;
      zero        = 1'b1;
      instr       = 32'h0022_1820;

      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check('0, 0, "reset", k);
      end
      @(posedge clk);
      #1 reset_a = 1'b1;

      run(32'h0022_1820, C_ADD,  1'b0, 0, "add");
      run(32'h8C22_0004, C_LW,   1'b0, 0, "lw");
      run(32'hAC22_0004, C_SW,   1'b0, 0, "sw");
      run(32'h1022_0003, C_BEQ,  1'b1, 0, "beq_taken");
      run(32'h1022_0003, C_BEQ,  1'b0, 0, "beq_not");
      run(32'h0022_0018, C_MULT, 1'b0, 0, "mult");
      run(32'h0000_1810, C_MFHI, 1'b0, 0, "mfhi");
      run(32'hFC00_0000, C_UND,  1'b0, 0, "undef");
      run(32'h0022_001A, C_DIV,  1'b0, 0, "div");
      run(32'h0000_1812, C_MFLO, 1'b0, 0, "mflo");
      run(32'h0C00_0010, C_JAL,  1'b0, 0, "jal");
      run(32'h03E0_0008, C_JR,   1'b0, 0, "jr");
      run(32'h3422_00FF, C_ORI,  1'b0, 0, "ori");
      run(32'h3C02_1234, C_LUI,  1'b0, 0, "lui");

      repeat (80) begin
         cls = int'($urandom_range(0, 13));
         run(enc(cls), cls, 1'($urandom), 0, "rand");
      end

      // abort div in its third MDWAIT cycle
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 0) instr = 32'h0022_001A;
         check(model(C_DIV, k, 1'b0, 10), 0, "abort_pre", k);
      end
      #1 reset_a = 1'b0;
      #1 check('0, 0, "abort_now", 0);
      for (int k = 1; k < 10; k++) begin
         @(negedge clk);
         check('0, 0, "abort_hold", k);
      end
      @(posedge clk);
      #1 reset_a = 1'b1;
      run(32'h0022_001A, C_DIV, 1'b0, 0, "div_reload");

      // DIV_CYCLES=1 instance
      @(negedge clk);
      check('0, 1, "b_reset", 0);
      reset_a = 1'b0;
      @(posedge clk);
      #1 reset_b = 1'b1;
      run(32'h0022_001A, C_DIV,  1'b0, 1, "div_lat1");
      run(32'h0022_0018, C_MULT, 1'b0, 1, "b_mult");
      run(32'h0022_001A, C_DIV,  1'b0, 1, "div_lat1_again");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
